// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD message scheduler: message codes,
// FSM states and the counter-width helper.
package lcd_pkg;

    localparam logic [3:0] MSG_WELCOME     = 4'd0;
    localparam logic [3:0] MSG_INSERT_COIN = 4'd1;
    localparam logic [3:0] MSG_INSERTED    = 4'd2;
    localparam logic [3:0] MSG_SELECT      = 4'd3;
    localparam logic [3:0] MSG_PROD1       = 4'd4;
    localparam logic [3:0] MSG_PROD2       = 4'd5;
    localparam logic [3:0] MSG_PROD3       = 4'd6;
    localparam logic [3:0] MSG_PROD4       = 4'd7;
    localparam logic [3:0] MSG_PROD5       = 4'd8;
    localparam logic [3:0] MSG_PROD6       = 4'd9;
    localparam logic [3:0] MSG_PRESS_A     = 4'd10;
    localparam logic [3:0] MSG_SELECTED    = 4'd11;
    localparam logic [3:0] MSG_WAIT        = 4'd12;
    localparam logic [3:0] MSG_TAKE        = 4'd13;
    localparam logic [3:0] MSG_TAKEN       = 4'd14;
    localparam logic [3:0] MSG_SEE_YOU     = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SHOW = 2'd2
    } sched_state_e;

    // Width able to hold the larger of the two cycle limits without wrapping.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/lcd_msg_scheduler_if.sv
// Requester-side bus of the LCD message scheduler: level requests with their
// message codes in, grant pulse and LCD message-select out.
interface lcd_msg_scheduler_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [4*N_REQ-1:0] req_msg;
    logic [N_REQ-1:0]   grant;
    logic [3:0]         edo_lcd;
    logic               busy;
    logic               msg_changed;

    modport master (
        output req, req_msg,
        input  grant, edo_lcd, busy, msg_changed
    );

    modport slave (
        input  req, req_msg,
        output grant, edo_lcd, busy, msg_changed
    );
endinterface

// File: rtl/lcd_msg_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    function automatic int rot(input int p, input int i);
        return (p + i) % N_REQ;
    endfunction

    // Scanning from the far end lets the candidate nearest ptr overwrite the rest.
    always_comb begin
        // NOTE: every output gets a default before any conditional assignment,
        // otherwise synthesis infers a latch for the unassigned paths.
        idx   = '0;
        gnt   = '0;
        valid = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[rot(int'(ptr), i)]) idx = PTR_W'(rot(int'(ptr), i));
        end
        if (valid) gnt[idx] = 1'b1;
    end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Arbitrates message requests onto the LCD message-select code with a minimum
// hold time and an inactivity revert. Optional macro: LCD_SCHED_PREEMPT_EN.
module lcd_msg_scheduler
    import lcd_pkg::*;
#(
    parameter int         N_REQ       = 4,
    parameter int         HOLD_CYC    = 50000000,
    parameter int         IDLE_TO_CYC = 500000000,
    parameter logic [3:0] DEFAULT_MSG = MSG_WELCOME
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_msg_scheduler_if.slave  bus
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = cnt_width(HOLD_CYC, IDLE_TO_CYC);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TO_CYC - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(N_REQ - 1);

    sched_state_e     state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [3:0]       edo_q, edo_d;
    logic             msg_changed_q, msg_changed_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0] arb_idx;
    logic             arb_valid;

    logic             urgent;
    logic             win_valid;
    logic [PTR_W-1:0] win_idx;
    logic [N_REQ-1:0] win_gnt;
    logic [3:0]       win_msg;
    logic             do_grant;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (bus.req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

`ifdef LCD_SCHED_PREEMPT_EN
    assign urgent = bus.req[0];
`else
    assign urgent = 1'b0;
`endif

    assign win_valid = urgent | arb_valid;
    assign win_idx   = urgent ? '0 : arb_idx;
    assign win_gnt   = urgent ? {{(N_REQ-1){1'b0}}, 1'b1} : arb_gnt;
    assign win_msg   = bus.req_msg[{win_idx, 2'b00} +: 4];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        idle_cnt_d = idle_cnt_q;
        grant_d    = '0;
        edo_d      = edo_q;
        do_grant   = 1'b0;

        unique case (state_q)
            IDLE: do_grant = win_valid;
            HOLD: begin
                if (urgent) begin
                    do_grant = 1'b1;
                end else if (hold_cnt_q == '0) begin
                    state_d    = SHOW;
                    idle_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            SHOW: begin
                // A request in the timeout cycle wins over the revert.
                if (win_valid) begin
                    do_grant = 1'b1;
                end else if (idle_cnt_q >= IDLE_LAST) begin
                    state_d    = IDLE;
                    edo_d      = DEFAULT_MSG;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_grant) begin
            grant_d    = win_gnt;
            edo_d      = win_msg;
            state_d    = HOLD;
            hold_cnt_d = HOLD_LOAD;
            idle_cnt_d = '0;
            // Urgent grants leave the rotation where it was.
            if (!urgent) ptr_d = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;
        end

        msg_changed_d = (edo_d != edo_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state flops use non-blocking assignment so every flop samples
        // the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            grant_q       <= '0;
            edo_q         <= DEFAULT_MSG;
            msg_changed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            grant_q       <= grant_d;
            edo_q         <= edo_d;
            msg_changed_q <= msg_changed_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.edo_lcd     = edo_q;
    assign bus.busy        = (state_q == HOLD);
    assign bus.msg_changed = msg_changed_q;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
// Self-checking bench for lcd_msg_scheduler: cycle model of the scheduling
// rules plus directed scenarios with literal expectations.
module tb_lcd_msg_scheduler;
    import lcd_pkg::*;

    localparam int N       = 4;
    localparam int HOLD_C  = 5;
    localparam int IDLE_C  = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    bit   cmp_en;

    lcd_msg_scheduler_if #(.N_REQ(N)) bus ();

    lcd_msg_scheduler #(
        .N_REQ       (N),
        .HOLD_CYC    (HOLD_C),
        .IDLE_TO_CYC (IDLE_C),
        .DEFAULT_MSG (MSG_WELCOME)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: display mode, cycles of hold left, cycles spent showing.
    localparam int M_IDLE = 0, M_HOLD = 1, M_SHOW = 2;
    int         m_mode;
    int         m_hold_left;
    int         m_show_age;
    int         m_ptr;
    logic [3:0] m_grant;
    logic [3:0] m_edo;
    logic       m_changed;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode = M_IDLE; m_hold_left = 0; m_show_age = 0; m_ptr = 0;
                m_grant = '0; m_edo = MSG_WELCOME; m_changed = 1'b0;
            end else begin
                logic [3:0] old_edo;
                int  win;
                bit  urg;
                old_edo = m_edo;
                m_grant = '0;
                win = -1;
                urg = 1'b0;
`ifdef LCD_SCHED_PREEMPT_EN
                if (bus.req[0]) begin
                    win = 0;
                    urg = 1'b1;
                end
`endif
                if (win < 0 && m_mode != M_HOLD) begin
                    for (int i = 0; i < N; i++) begin
                        if (win < 0 && bus.req[(m_ptr + i) % N]) win = (m_ptr + i) % N;
                    end
                end
                if (win >= 0) begin
                    m_grant[win] = 1'b1;
                    m_edo        = bus.req_msg[win*4 +: 4];
                    m_mode       = M_HOLD;
                    m_hold_left  = HOLD_C;
                    if (!urg) m_ptr = (win + 1) % N;
                end else if (m_mode == M_HOLD) begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin
                        m_mode     = M_SHOW;
                        m_show_age = 0;
                    end
                end else if (m_mode == M_SHOW) begin
                    m_show_age++;
                    if (m_show_age == IDLE_C) begin
                        m_mode = M_IDLE;
                        m_edo  = MSG_WELCOME;
                    end
                end
                m_changed = (m_edo != old_edo);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cmp_en) begin
                check("cyc_grant",   bus.grant,       m_grant);
                check("cyc_edo",     bus.edo_lcd,     m_edo);
                check("cyc_busy",    bus.busy,        m_mode == M_HOLD);
                check("cyc_changed", bus.msg_changed, m_changed);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    // Advance one cycle; requesters drop their line once they see their grant.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) if (bus.grant[i]) bus.req[i] = 1'b0;
    endtask

    task automatic request(input int idx, input logic [3:0] code);
        bus.req_msg[idx*4 +: 4] = code;
        bus.req[idx] = 1'b1;
    endtask

    task automatic wait_show();
        for (int i = 0; i < 40 && bus.busy; i++) tick();
        check("wait_show_busy", bus.busy, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req = '0;
        tick();
        rst_n = 1'b1;
    endtask

    int n;

    initial begin
        n_cmp = 0; n_bad = 0; cmp_en = 1'b0;
        rst_n = 1'b0;
        bus.req = '0;
        bus.req_msg = '0;
        repeat (3) @(negedge clk);
        check("rst_edo",     bus.edo_lcd,     4'd0);
        check("rst_grant",   bus.grant,       4'b0000);
        check("rst_busy",    bus.busy,        1'b0);
        check("rst_changed", bus.msg_changed, 1'b0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // No requests: WELCOME stays up, no timeout from IDLE.
        repeat (12) tick();
        check("idle_edo", bus.edo_lcd, 4'd0);

        // Single request, hold length.
        request(1, MSG_SELECT);
        tick();
        check("g1_grant",   bus.grant,       4'b0010);
        check("g1_edo",     bus.edo_lcd,     4'd3);
        check("g1_changed", bus.msg_changed, 1'b1);
        n = 1;
        for (int i = 0; i < 20 && bus.busy; i++) begin
            tick();
            if (bus.busy) n++;
        end
        check("g1_busy_len", n, HOLD_C);

        // Two simultaneous requests from pointer 0.
        do_reset();
        request(0, MSG_PROD1);
        request(2, MSG_PROD2);
        tick();
        check("rr_first_grant", bus.grant,   4'b0001);
        check("rr_first_edo",   bus.edo_lcd, 4'd4);
        for (n = 1; n <= 20; n++) begin
            tick();
            if (bus.grant[2]) break;
        end
        check("rr_second_gap", n, HOLD_C + 1);
        check("rr_second_edo", bus.edo_lcd, 4'd5);

        // Inactivity revert after IDLE_C show cycles.
        wait_show();
        for (n = 1; n <= 20; n++) begin
            tick();
            if (bus.edo_lcd == 4'd0) break;
        end
        check("to_cycles",  n, IDLE_C);
        check("to_changed", bus.msg_changed, 1'b1);

        // Request in the timeout cycle wins.
        request(3, MSG_PROD4);
        tick();
        check("race_pre_grant", bus.grant, 4'b1000);
        wait_show();
        repeat (IDLE_C - 1) tick();
        check("race_no_early_revert", bus.edo_lcd, 4'd7);
        request(1, MSG_PROD6);
        tick();
        check("race_grant",   bus.grant,       4'b0010);
        check("race_edo",     bus.edo_lcd,     4'd9);
        check("race_changed", bus.msg_changed, 1'b1);

        // Pending-during-hold, dropped request, and same-code re-grant.
        request(3, MSG_WAIT);
        tick();
        tick();
        bus.req[3] = 1'b0;
        request(2, MSG_TAKE);
        wait_show();
        tick();
        check("pend_grant", bus.grant,   4'b0100);
        check("pend_edo",   bus.edo_lcd, 4'd13);
        request(1, MSG_TAKE);
        wait_show();
        tick();
        check("same_grant",   bus.grant,       4'b0010);
        check("same_edo",     bus.edo_lcd,     4'd13);
        check("same_changed", bus.msg_changed, 1'b0);
        check("same_busy",    bus.busy,        1'b1);

        // Asynchronous reset in the middle of HOLD.
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        bus.req = '0;
        #1;
        check("arst_edo",   bus.edo_lcd, 4'd0);
        check("arst_busy",  bus.busy,    1'b0);
        check("arst_grant", bus.grant,   4'b0000);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("arst_after_edo", bus.edo_lcd, 4'd0);

`ifdef LCD_SCHED_PREEMPT_EN
        // Urgent requester interrupts HOLD.
        request(2, MSG_PROD2);
        tick();
        check("pre_base_grant", bus.grant, 4'b0100);
        tick();
        request(0, MSG_WAIT);
        tick();
        check("pre_grant", bus.grant,   4'b0001);
        check("pre_edo",   bus.edo_lcd, 4'd12);
        n = 1;
        for (int i = 0; i < 20 && bus.busy; i++) begin
            tick();
            if (bus.busy) n++;
        end
        check("pre_busy_len", n, HOLD_C);
`endif

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
